// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch resolution bus: IF prediction lookup, EX request and registered result.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_branch;
  logic            ex_stall;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic            ex_pred_taken;
  logic            res_valid;
  logic            res_taken;
  logic            res_illegal;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  modport master (
    output if_pc, ex_valid, ex_branch, ex_stall, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm,
           ex_pred_taken,
    input  if_pred_taken, res_valid, res_taken, res_illegal, mispredict, redirect_pc, flush
  );

  modport slave (
    input  if_pc, ex_valid, ex_branch, ex_stall, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm,
           ex_pred_taken,
    output if_pred_taken, res_valid, res_taken, res_illegal, mispredict, redirect_pc, flush
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch condition evaluation, registered resolution/redirect, mispredict flush sequencer
// and a 2-bit saturating branch history table feeding IF predictions.
module branch_resolve_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BHT_ENTRIES  = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int unsigned IDX = $clog2(BHT_ENTRIES);
  localparam int unsigned CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            taken, illegal, mispred, acc;
  logic [XLEN-1:0] target;
  logic [IDX-1:0]  wr_idx;
  logic [1:0]      bht_q [BHT_ENTRIES];

  logic            res_valid_q, res_taken_q, res_illegal_q, mispredict_q;
  logic [XLEN-1:0] redirect_q;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (bus.ex_funct3)
      3'b000:  taken = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  taken = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  taken = ($signed(bus.ex_rs1) < $signed(bus.ex_rs2));
      3'b101:  taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  taken = (bus.ex_rs1 < bus.ex_rs2);
      3'b111:  taken = (bus.ex_rs1 >= bus.ex_rs2);
      default: illegal = 1'b1;
    endcase
  end

  assign target  = taken ? (bus.ex_pc + bus.ex_imm) : (bus.ex_pc + XLEN'(4));
  assign mispred = taken ^ bus.ex_pred_taken;
  // Anything reaching EX while flushing is wrong-path and must not resolve or train.
  assign acc     = bus.ex_valid & bus.ex_branch & ~bus.ex_stall & (state_q == StIdle);
  assign wr_idx  = bus.ex_pc[IDX+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (acc && mispred) begin
          state_d = StFlush;
          cnt_d   = CW'(FLUSH_CYCLES - 1);
        end
      end
      StFlush: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // res_taken/redirect_pc keep the last resolution; the strobes clear when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_q    <= '0;
    end else begin
      res_valid_q   <= acc;
      res_illegal_q <= acc & illegal;
      mispredict_q  <= acc & mispred;
      if (acc) begin
        res_taken_q <= taken;
        redirect_q  <= target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else if (acc && !illegal) begin
      if (taken && bht_q[wr_idx] != 2'b11)       bht_q[wr_idx] <= bht_q[wr_idx] + 2'b01;
      else if (!taken && bht_q[wr_idx] != 2'b00) bht_q[wr_idx] <= bht_q[wr_idx] - 2'b01;
    end
  end

  assign bus.if_pred_taken = bht_q[bus.if_pc[IDX+1:2]][1];
  assign bus.res_valid     = res_valid_q;
  assign bus.res_taken     = res_taken_q;
  assign bus.res_illegal   = res_illegal_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.redirect_pc   = redirect_q;
  assign bus.flush         = (state_q == StFlush);
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed vector table plus hand-written flush, BHT, illegal/stall and reset sequences.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (16),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        taken;
    logic        illegal;
    logic        mis;
    logic [31:0] redir;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic v, input logic t, input logic il,
                          input logic m, input logic [31:0] r, input logic fl);
    chk($sformatf("%s.res_valid", name), 32'(bus.res_valid), 32'(v));
    chk($sformatf("%s.res_taken", name), 32'(bus.res_taken), 32'(t));
    chk($sformatf("%s.res_illegal", name), 32'(bus.res_illegal), 32'(il));
    chk($sformatf("%s.mispredict", name), 32'(bus.mispredict), 32'(m));
    chk($sformatf("%s.redirect_pc", name), bus.redirect_pc, r);
    chk($sformatf("%s.flush", name), 32'(bus.flush), 32'(fl));
  endtask

  task automatic idle();
    bus.ex_valid      = 1'b0;
    bus.ex_branch     = 1'b0;
    bus.ex_stall      = 1'b0;
    bus.ex_funct3     = 3'b000;
    bus.ex_rs1        = '0;
    bus.ex_rs2        = '0;
    bus.ex_pc         = '0;
    bus.ex_imm        = '0;
    bus.ex_pred_taken = 1'b0;
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    bus.ex_valid      = 1'b1;
    bus.ex_branch     = 1'b1;
    bus.ex_stall      = 1'b0;
    bus.ex_funct3     = f3;
    bus.ex_rs1        = rs1;
    bus.ex_rs2        = rs2;
    bus.ex_pc         = pc;
    bus.ex_imm        = imm;
    bus.ex_pred_taken = pred;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
    bus.if_pc = pc;
    #1;
    chk(name, 32'(bus.if_pred_taken), 32'(exp));
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'd5, 32'd5, 32'h200, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h210};
    vecs[1]  = '{3'b000, 32'd5, 32'd6, 32'h204, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208};
    vecs[2]  = '{3'b001, 32'd5, 32'd6, 32'h208, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h218};
    vecs[3]  = '{3'b100, 32'hFFFFFFFF, 32'd1, 32'h20C, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h21C};
    vecs[4]  = '{3'b110, 32'hFFFFFFFF, 32'd1, 32'h210, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h214};
    vecs[5]  = '{3'b101, 32'hFFFFFFFF, 32'd1, 32'h214, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h218};
    vecs[6]  = '{3'b111, 32'hFFFFFFFF, 32'd1, 32'h218, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h228};
    vecs[7]  = '{3'b101, 32'd3, 32'd3, 32'h21C, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h22C};
    vecs[8]  = '{3'b010, 32'd5, 32'd5, 32'h220, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h224};
    vecs[9]  = '{3'b001, 32'd1, 32'd1, 32'hFFFFFFFC, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{3'b000, 32'd0, 32'd0, 32'h1000, 32'hFFFFFFF0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFF0};
    vecs[11] = '{3'b011, 32'd1, 32'd2, 32'h300, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 32'h304};
    vecs[12] = '{3'b110, 32'd1, 32'hFFFFFFFF, 32'h304, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h30C};
    vecs[13] = '{3'b001, 32'd7, 32'd7, 32'h308, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h30C};
    vecs[14] = '{3'b111, 32'd1, 32'd2, 32'h30C, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h310};
    vecs[15] = '{3'b100, 32'd1, 32'hFFFFFFFF, 32'h310, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h314};

    bus.if_pc = '0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) chk_pred($sformatf("reset_bht[%0d]", i), 32'(i) << 2, 1'b0);

    // Back-to-back table: every vector is predicted correctly so nothing gets flushed.
    for (int i = 0; i < 16; i++) begin
      present(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm, vecs[i].pred);
      tick();
      chk_outs($sformatf("vec%0d", i), 1'b1, vecs[i].taken, vecs[i].illegal, vecs[i].mis,
               vecs[i].redir, 1'b0);
    end
    idle();
    tick();
    chk_outs("after_table", 1'b0, 1'b0, 1'b0, 1'b0, 32'h314, 1'b0);

    // Mispredict, two-cycle flush, wrong-path bne ignored.
    do_reset();
    present(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    tick();
    chk_outs("mis_t1", 1'b1, 1'b1, 1'b0, 1'b1, 32'h120, 1'b1);
    present(3'b001, 32'd1, 32'd2, 32'h104, 32'h8, 1'b0);
    tick();
    chk_outs("mis_t2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h120, 1'b1);
    tick();
    chk_outs("mis_t3", 1'b0, 1'b1, 1'b0, 1'b0, 32'h120, 1'b0);
    idle();
    chk_pred("mis_bht_wrongpath", 32'h104, 1'b0);
    chk_pred("mis_bht_trained", 32'h100, 1'b1);

    // Reset during a flush aborts it asynchronously and reinitialises the BHT.
    present(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    tick();
    idle();
    chk("midrst_flush_before", 32'(bus.flush), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_pred("midrst_bht", 32'h100, 1'b0);
    tick();
    rst = 1'b0;

    // BHT saturation at both ends, including the same-cycle read/write collision.
    do_reset();
    bus.if_pc = 32'h40;
    present(3'b000, 32'd9, 32'd9, 32'h40, 32'h4, 1'b1);
    #1;
    chk("bht_collision_old", 32'(bus.if_pred_taken), 32'd0);
    tick();
    chk("bht_t1", 32'(bus.if_pred_taken), 32'd1);
    chk("bht_t1_mis", 32'(bus.mispredict), 32'd0);
    tick();
    chk("bht_t2", 32'(bus.if_pred_taken), 32'd1);
    tick();
    chk("bht_t3_sat", 32'(bus.if_pred_taken), 32'd1);
    present(3'b000, 32'd9, 32'd8, 32'h40, 32'h4, 1'b0);
    tick();
    chk("bht_n1", 32'(bus.if_pred_taken), 32'd1);
    tick();
    chk("bht_n2", 32'(bus.if_pred_taken), 32'd0);
    tick();
    chk("bht_n3", 32'(bus.if_pred_taken), 32'd0);
    tick();
    chk("bht_n4_sat", 32'(bus.if_pred_taken), 32'd0);
    present(3'b000, 32'd9, 32'd9, 32'h40, 32'h4, 1'b1);
    tick();
    chk("bht_up1", 32'(bus.if_pred_taken), 32'd0);
    tick();
    chk("bht_up2", 32'(bus.if_pred_taken), 32'd1);
    idle();
    tick();

    // Illegal funct3 predicted taken, then stalled and non-branch slots.
    do_reset();
    bus.if_pc = 32'h80;
    present(3'b000, 32'd5, 32'd5, 32'h80, 32'h40, 1'b1);
    tick();
    chk("ill_pre_bht", 32'(bus.if_pred_taken), 32'd1);
    present(3'b010, 32'd5, 32'd6, 32'h80, 32'h40, 1'b1);
    tick();
    chk_outs("ill", 1'b1, 1'b0, 1'b1, 1'b1, 32'h84, 1'b1);
    chk("ill_bht", 32'(bus.if_pred_taken), 32'd1);
    idle();
    tick();
    tick();
    chk("ill_flush_done", 32'(bus.flush), 32'd0);
    present(3'b000, 32'd5, 32'd6, 32'h80, 32'h40, 1'b0);
    bus.ex_stall = 1'b1;
    tick();
    chk_outs("stall", 1'b0, 1'b0, 1'b0, 1'b0, 32'h84, 1'b0);
    chk("stall_bht", 32'(bus.if_pred_taken), 32'd1);
    bus.ex_stall  = 1'b0;
    bus.ex_branch = 1'b0;
    tick();
    chk("nonbranch_valid", 32'(bus.res_valid), 32'd0);
    chk("nonbranch_bht", 32'(bus.if_pred_taken), 32'd1);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
